// File: rtl/pipelined_alu_seq.sv
// Registered ALU with valid/ready handshakes and an iterative shift-add multiplier.
// ALU ops complete in one cycle; multiplies take WIDTH iterations before DONE.
module pipelined_alu_seq #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             cout,
  output logic             G,
  output logic             P,
  output logic             set,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e               state_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [CW-1:0]        cnt_q;

  logic                 is_mul;
  logic [WIDTH-1:0]     bb;
  logic [WIDTH:0]       sum0;
  logic [WIDTH:0]       sum;
  logic                 alu_p;
  logic                 ovf_raw;
  logic                 alu_set;
  logic [WIDTH-1:0]     alu_res;
  logic [2*WIDTH-1:0]   acc_next;

  always_comb begin
    is_mul  = (MUL_EN != 0) && op[3];
    bb      = op[2] ? ~b : b;
    // sum0 is the cin=0 sum; its carry is the group generate.
    sum0    = {1'b0, a} + {1'b0, bb};
    sum     = sum0 + {{WIDTH{1'b0}}, op[2]};
    alu_p   = &(a | bb);
    ovf_raw = (a[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    alu_set = sum[WIDTH-1] ^ ovf_raw;
    unique case (op[1:0])
      2'b00:   alu_res = a & bb;
      2'b01:   alu_res = a | bb;
      2'b10:   alu_res = sum[WIDTH-1:0];
      default: alu_res = {{(WIDTH-1){1'b0}}, alu_set};
    endcase
    acc_next = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      cout      <= 1'b0;
      G         <= 1'b0;
      P         <= 1'b0;
      set       <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (is_mul) begin
              mcand_q  <= {{WIDTH{1'b0}}, a};
              mplier_q <= b;
              acc_q    <= '0;
              cnt_q    <= '0;
              state_q  <= StMul;
            end else begin
              result    <= alu_res;
              result_hi <= '0;
              cout      <= sum[WIDTH];
              G         <= sum0[WIDTH];
              P         <= alu_p;
              set       <= alu_set;
              overflow  <= (op[1:0] == 2'b10) ? ovf_raw : 1'b0;
              zero      <= (alu_res == '0);
              out_valid <= 1'b1;
              state_q   <= StDone;
            end
          end
        end
        StMul: begin
          acc_q    <= acc_next;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            result    <= acc_next[WIDTH-1:0];
            result_hi <= acc_next[2*WIDTH-1:WIDTH];
            cout      <= 1'b0;
            G         <= 1'b0;
            P         <= 1'b0;
            set       <= 1'b0;
            overflow  <= (acc_next[2*WIDTH-1:WIDTH] != '0);
            zero      <= (acc_next == '0);
            out_valid <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pipelined_alu_seq.sv
// Directed bench for pipelined_alu_seq at WIDTH=4 with hand-computed expectations.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_pipelined_alu_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] result;
  logic [3:0] result_hi;
  logic       cout;
  logic       G;
  logic       P;
  logic       set;
  logic       overflow;
  logic       zero;
  logic [5:0] flags;

  int checks   = 0;
  int failures = 0;

  assign flags = {cout, G, P, set, overflow, zero};

  pipelined_alu_seq #(
    .WIDTH (4),
    .MUL_EN(1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .result_hi(result_hi),
    .cout     (cout),
    .G        (G),
    .P        (P),
    .set      (set),
    .overflow (overflow),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // flags order: {cout, G, P, set, overflow, zero}
  task automatic run_alu(input string tag, input logic [3:0] ta, input logic [3:0] tbv,
                         input logic [3:0] top, input logic [3:0] exp_res,
                         input logic [5:0] exp_flags);
    @(negedge clk);
    check_eq({tag, "_in_ready"}, 16'(in_ready), 16'd1);
    a         = ta;
    b         = tbv;
    op        = top;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check_eq({tag, "_out_valid"}, 16'(out_valid), 16'd1);
    check_eq({tag, "_result"}, 16'(result), 16'(exp_res));
    check_eq({tag, "_result_hi"}, 16'(result_hi), 16'd0);
    check_eq({tag, "_flags"}, 16'(flags), 16'(exp_flags));
    @(negedge clk);
    check_eq({tag, "_valid_drop"}, 16'(out_valid), 16'd0);
    check_eq({tag, "_ready_back"}, 16'(in_ready), 16'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    op        = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", 16'(in_ready), 16'd1);
    check_eq("rst_out_valid", 16'(out_valid), 16'd0);
    check_eq("rst_result", 16'(result), 16'd0);
    check_eq("rst_result_hi", 16'(result_hi), 16'd0);
    check_eq("rst_flags", 16'(flags), 16'd0);
    rst = 1'b0;

    run_alu("or",      4'b1101, 4'b1001, 4'b0001, 4'b1101, 6'b110100);
    run_alu("or_binv", 4'b1101, 4'b1001, 4'b0101, 4'b1111, 6'b111000);
    run_alu("sub_ovf", 4'b0001, 4'b1000, 4'b0110, 4'b1001, 6'b000010);
    run_alu("sub_eq",  4'b0101, 4'b0101, 4'b0110, 4'b0000, 6'b101001);
    run_alu("slt",     4'b1110, 4'b0011, 4'b0111, 4'b0001, 6'b110100);

    // Multiply 13 * 11 = 143 with the consumer stalled.
    @(negedge clk);
    a         = 4'b1101;
    b         = 4'b1011;
    op        = 4'b1010;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      check_eq($sformatf("mul_valid_c%0d", k), 16'(out_valid), (k == 5) ? 16'd1 : 16'd0);
    end
    check_eq("mul_result", 16'(result), 16'hf);
    check_eq("mul_result_hi", 16'(result_hi), 16'h8);
    check_eq("mul_flags", 16'(flags), 16'(6'b000010));
    a        = 4'b0000;
    b        = 4'b0000;
    op       = 4'b0000;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("stall_valid", 16'(out_valid), 16'd1);
      check_eq("stall_in_ready", 16'(in_ready), 16'd0);
      check_eq("stall_result", 16'({result_hi, result}), 16'h8f);
      check_eq("stall_flags", 16'(flags), 16'(6'b000010));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("release_valid", 16'(out_valid), 16'd0);
    check_eq("release_in_ready", 16'(in_ready), 16'd1);
    @(negedge clk);
    check_eq("no_ghost_accept", 16'(out_valid), 16'd0);

    // Reset during the second multiply iteration.
    a        = 4'b1111;
    b        = 4'b1111;
    op       = 4'b1000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mrst_out_valid", 16'(out_valid), 16'd0);
    check_eq("mrst_in_ready", 16'(in_ready), 16'd1);
    check_eq("mrst_result", 16'({result_hi, result}), 16'h00);
    check_eq("mrst_flags", 16'(flags), 16'd0);

    run_alu("add_ovf", 4'b0111, 4'b0001, 4'b0010, 4'b1000, 6'b000010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
